// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MEM stage:
// size codes, FSM states, byte strobes, store steering, load formatting.
package mem_stage_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Illegal size code counts as misaligned so it never touches memory.
   function automatic logic misaligned(
      input logic [1:0] size,
      input logic [1:0] off
   );
      logic m;
      case (size)
         SZ_B:    m = 1'b0;
         SZ_H:    m = off[0];
         SZ_W:    m = (off != 2'b00);
         default: m = 1'b1;
      endcase
      return m;
   endfunction

   function automatic logic [3:0] byte_strb(
      input logic [1:0] size,
      input logic [1:0] off
   );
      logic [3:0] s;
      case (size)
         SZ_B:    s = 4'b0001 << off;
         SZ_H:    s = off[1] ? 4'b1100 : 4'b0011;
         SZ_W:    s = 4'b1111;
         default: s = 4'b0000;
      endcase
      return s;
   endfunction

   // Replicate the low bytes so every strobed lane sees the right data.
   function automatic logic [31:0] store_data(
      input logic [1:0]  size,
      input logic [31:0] data
   );
      logic [31:0] d;
      case (size)
         SZ_B:    d = {4{data[7:0]}};
         SZ_H:    d = {2{data[15:0]}};
         default: d = data;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] load_fmt(
      input logic [31:0] word,
      input logic [1:0]  size,
      input logic [1:0]  off,
      input logic        uns
   );
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_B: r = uns ? {24'd0, b} : {{24{b[7]}}, b};
         SZ_H: r = uns ? {16'd0, h} : {{16{h[15]}}, h};
         SZ_W: r = word;
         default: r = 32'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_stage_ls_if.sv
// EX->MEM request and MEM->WB response bundle.
// master = EX/WB side driving requests, slave = MEM stage.
interface mem_stage_ls_if #(
   parameter int RA_W = 5
) ();

   logic            i_MEM_valid;
   logic            o_MEM_ready;
   logic            i_MEM_regWe;
   logic            i_MEM_memRe;
   logic            i_MEM_memWe;
   logic [1:0]      i_MEM_size;
   logic            i_MEM_unsigned;
   logic [RA_W-1:0] i_MEM_WRA;
   logic [31:0]     i_MEM_aluOut;
   logic [31:0]     i_MEM_rd2;

   logic            o_MEM_valid;
   logic            o_MEM_regWe;
   logic [RA_W-1:0] o_MEM_WRA;
   logic [31:0]     o_MEM_aluOut;
   logic [31:0]     o_MEM_rData;
   logic            o_MEM_isLoad;
   logic            o_MEM_misalign;

   modport master (
      output i_MEM_valid, i_MEM_regWe, i_MEM_memRe,
      output i_MEM_memWe, i_MEM_size, i_MEM_unsigned,
      output i_MEM_WRA, i_MEM_aluOut, i_MEM_rd2,
      input  o_MEM_ready, o_MEM_valid, o_MEM_regWe,
      input  o_MEM_WRA, o_MEM_aluOut, o_MEM_rData,
      input  o_MEM_isLoad, o_MEM_misalign
   );

   modport slave (
      input  i_MEM_valid, i_MEM_regWe, i_MEM_memRe,
      input  i_MEM_memWe, i_MEM_size, i_MEM_unsigned,
      input  i_MEM_WRA, i_MEM_aluOut, i_MEM_rd2,
      output o_MEM_ready, o_MEM_valid, o_MEM_regWe,
      output o_MEM_WRA, o_MEM_aluOut, o_MEM_rData,
      output o_MEM_isLoad, o_MEM_misalign
   );

endinterface

// File: rtl/mem_lane_ram.sv
// DEPTH x 32 data memory, four byte-lane write strobes.
// Ports: clk, we[3:0], addr (word index), wdata; rdata is async read.
module mem_lane_ram #(
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic [3:0]               we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage_ls.sv
// MEM pipeline stage: loads/stores with wait states, misalign check, ALU passthrough.
// Ports: clk, rstn (async active-low), bus (slave: EX request in, WB result out).
module mem_stage_ls
   import mem_stage_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 0,
   parameter int RA_W        = 5
) (
   input logic           clk,
   input logic           rstn,
   mem_stage_ls_if.slave bus
);

   localparam int AW = $clog2(DEPTH);

   state_e          state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;

   logic            regwe_q, regwe_d;
   logic            load_q, load_d;
   logic            store_q, store_d;
   logic [1:0]      size_q, size_d;
   logic            uns_q, uns_d;
   logic [RA_W-1:0] wra_q, wra_d;
   logic [31:0]     alu_q, alu_d;
   logic [31:0]     wdata_q, wdata_d;

   // WB-facing fields hold the last response outside RESP.
   logic [RA_W-1:0] hwra_q, hwra_d;
   logic [31:0]     halu_q, halu_d;
   logic [31:0]     hrdata_q, hrdata_d;
   logic            hload_q, hload_d;

   logic            ready;
   logic            accept;
   logic            in_mem;
   logic            resp;
   logic            mis;
   logic [31:0]     ram_rdata;
   logic [31:0]     live_rdata;
   logic [3:0]      ram_we;

   assign ready  = (state_q == ST_IDLE) || (state_q == ST_RESP);
   assign accept = bus.i_MEM_valid & ready;
   assign in_mem = bus.i_MEM_memRe | bus.i_MEM_memWe;
   assign resp   = (state_q == ST_RESP);
   assign mis    = (load_q | store_q) & misaligned(size_q, alu_q[1:0]);

   assign live_rdata = (load_q & ~mis)
                     ? load_fmt(ram_rdata, size_q, alu_q[1:0], uns_q)
                     : 32'd0;

   // The store commits on the edge that leaves RESP.
   assign ram_we = {4{resp & store_q & ~mis}} & byte_strb(size_q, alu_q[1:0]);

   mem_lane_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (alu_q[AW+1:2]),
      .wdata (store_data(size_q, wdata_q)),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      regwe_d  = regwe_q;
      load_d   = load_q;
      store_d  = store_q;
      size_d   = size_q;
      uns_d    = uns_q;
      wra_d    = wra_q;
      alu_d    = alu_q;
      wdata_d  = wdata_q;
      hwra_d   = hwra_q;
      halu_d   = halu_q;
      hrdata_d = hrdata_q;
      hload_d  = hload_q;

      unique case (state_q)
         ST_IDLE: begin
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d  = ST_IDLE;
            hwra_d   = wra_q;
            halu_d   = alu_q;
            hrdata_d = live_rdata;
            hload_d  = load_q;
         end
         default: state_d = ST_IDLE;
      endcase

      if (accept) begin
         regwe_d = bus.i_MEM_regWe;
         load_d  = bus.i_MEM_memRe;
         // A load takes priority when both strobes are set.
         store_d = bus.i_MEM_memWe & ~bus.i_MEM_memRe;
         size_d  = bus.i_MEM_size;
         uns_d   = bus.i_MEM_unsigned;
         wra_d   = bus.i_MEM_WRA;
         alu_d   = bus.i_MEM_aluOut;
         wdata_d = bus.i_MEM_rd2;
         if (in_mem && (WAIT_CYCLES != 0)) begin
            state_d = ST_WAIT;
            cnt_d   = 3'(WAIT_CYCLES);
         end else begin
            state_d = ST_RESP;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 3'd0;
         regwe_q  <= 1'b0;
         load_q   <= 1'b0;
         store_q  <= 1'b0;
         size_q   <= 2'd0;
         uns_q    <= 1'b0;
         wra_q    <= '0;
         alu_q    <= 32'd0;
         wdata_q  <= 32'd0;
         hwra_q   <= '0;
         halu_q   <= 32'd0;
         hrdata_q <= 32'd0;
         hload_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         regwe_q  <= regwe_d;
         load_q   <= load_d;
         store_q  <= store_d;
         size_q   <= size_d;
         uns_q    <= uns_d;
         wra_q    <= wra_d;
         alu_q    <= alu_d;
         wdata_q  <= wdata_d;
         hwra_q   <= hwra_d;
         halu_q   <= halu_d;
         hrdata_q <= hrdata_d;
         hload_q  <= hload_d;
      end
   end

   assign bus.o_MEM_ready    = ready;
   assign bus.o_MEM_valid    = resp;
   assign bus.o_MEM_regWe    = resp & regwe_q & ~mis;
   assign bus.o_MEM_misalign = resp & mis;
   assign bus.o_MEM_WRA      = resp ? wra_q : hwra_q;
   assign bus.o_MEM_aluOut   = resp ? alu_q : halu_q;
   assign bus.o_MEM_rData    = resp ? live_rdata : hrdata_q;
   assign bus.o_MEM_isLoad   = resp ? load_q : hload_q;

endmodule

// File: tb/tb_mem_stage_ls.sv
// Self-checking bench for mem_stage_ls: byte-level memory model,
// per-cycle compare, directed literal checks and random traffic.
module tb_mem_stage_ls;

   localparam int W     = 2;
   localparam int DEPTH = 1024;
   localparam int RA_W  = 5;

   logic clk = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   mem_stage_ls_if #(.RA_W(RA_W)) bus ();

   mem_stage_ls #(
      .DEPTH       (DEPTH),
      .WAIT_CYCLES (W),
      .RA_W        (RA_W)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   typedef struct {
      logic            regwe, re, we, uns;
      logic [1:0]      size;
      logic [RA_W-1:0] wra;
      logic [31:0]     alu, rd2;
      int              vcyc;
   } op_s;

   typedef struct {
      int              cyc;
      logic [RA_W-1:0] wra;
      logic [31:0]     alu, rdata;
      logic            isload, regwe, mis;
   } res_s;

   op_s  q[$];
   res_s vlog[$];
   logic [7:0] mb [DEPTH*4];

   int cyc = 0, nchk = 0, nerr = 0, acc_cnt = 0, rdy_low = 0;
   logic [RA_W-1:0] l_wra = '0;
   logic [31:0] l_alu = 0, l_rd = 0;
   logic l_ld = 0;

   always @(posedge clk) cyc++;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
      end
   endfunction

   // Executes one op against the byte array in acceptance order.
   function automatic res_s model_exec(op_s o);
      res_s r;
      int n, a;
      logic [31:0] v;
      logic mem, mis;
      mem = o.re | o.we;
      n = 1 << o.size;
      a = int'(o.alu % (DEPTH*4));
      mis = mem && (o.size == 2'd3 || (o.alu % n) != 0);
      r.cyc = o.vcyc;
      r.wra = o.wra;
      r.alu = o.alu;
      r.isload = o.re;
      r.mis = mis;
      r.regwe = o.regwe && !mis;
      r.rdata = 0;
      if (o.re && !mis) begin
         v = 0;
         for (int i = 0; i < n; i++) v |= 32'(mb[a+i]) << (8*i);
         if (!o.uns && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8*n)) - 1);
         r.rdata = v;
      end else if (o.we && !mis) begin
         for (int i = 0; i < n; i++) mb[a+i] = 8'(o.rd2 >> (8*i));
      end
      return r;
   endfunction

   always @(negedge clk) begin : cmp
      logic mready;
      res_s e, act;
      op_s o;
      if (!rstn) begin
         chk("rst_ready", 32'(bus.o_MEM_ready), 1);
         chk("rst_valid", 32'(bus.o_MEM_valid), 0);
         chk("rst_regwe", 32'(bus.o_MEM_regWe), 0);
         chk("rst_mis", 32'(bus.o_MEM_misalign), 0);
         chk("rst_wra", 32'(bus.o_MEM_WRA), 0);
         chk("rst_alu", bus.o_MEM_aluOut, 0);
         chk("rst_rdata", bus.o_MEM_rData, 0);
         chk("rst_isload", 32'(bus.o_MEM_isLoad), 0);
         q.delete();
         l_wra = '0; l_alu = 0; l_rd = 0; l_ld = 0;
      end else begin
         mready = (q.size() == 0) || (q[0].vcyc == cyc);
         chk("ready", 32'(bus.o_MEM_ready), 32'(mready));
         if (!bus.o_MEM_ready) rdy_low++;
         if (q.size() != 0 && q[0].vcyc == cyc) begin
            e = model_exec(q.pop_front());
            chk("valid", 32'(bus.o_MEM_valid), 1);
            chk("wra", 32'(bus.o_MEM_WRA), 32'(e.wra));
            chk("alu", bus.o_MEM_aluOut, e.alu);
            chk("rdata", bus.o_MEM_rData, e.rdata);
            chk("isload", 32'(bus.o_MEM_isLoad), 32'(e.isload));
            chk("regwe", 32'(bus.o_MEM_regWe), 32'(e.regwe));
            chk("mis", 32'(bus.o_MEM_misalign), 32'(e.mis));
            act.cyc = cyc;
            act.wra = bus.o_MEM_WRA;
            act.alu = bus.o_MEM_aluOut;
            act.rdata = bus.o_MEM_rData;
            act.isload = bus.o_MEM_isLoad;
            act.regwe = bus.o_MEM_regWe;
            act.mis = bus.o_MEM_misalign;
            vlog.push_back(act);
            l_wra = e.wra; l_alu = e.alu; l_rd = e.rdata; l_ld = e.isload;
         end else begin
            chk("idle_valid", 32'(bus.o_MEM_valid), 0);
            chk("idle_regwe", 32'(bus.o_MEM_regWe), 0);
            chk("idle_mis", 32'(bus.o_MEM_misalign), 0);
            chk("hold_wra", 32'(bus.o_MEM_WRA), 32'(l_wra));
            chk("hold_alu", bus.o_MEM_aluOut, l_alu);
            chk("hold_rdata", bus.o_MEM_rData, l_rd);
            chk("hold_isload", 32'(bus.o_MEM_isLoad), 32'(l_ld));
         end
         if (bus.i_MEM_valid && mready) begin
            o.regwe = bus.i_MEM_regWe;
            o.re = bus.i_MEM_memRe;
            o.we = bus.i_MEM_memWe;
            o.uns = bus.i_MEM_unsigned;
            o.size = bus.i_MEM_size;
            o.wra = bus.i_MEM_WRA;
            o.alu = bus.i_MEM_aluOut;
            o.rd2 = bus.i_MEM_rd2;
            o.vcyc = cyc + 1 + ((o.re || o.we) ? W : 0);
            q.push_back(o);
            acc_cnt++;
         end
      end
   end

   task automatic send(input logic re, we, input logic [1:0] sz,
                       input logic uns, regwe, input logic [RA_W-1:0] wra,
                       input logic [31:0] alu, rd2);
      int c0, n;
      bus.i_MEM_memRe = re;
      bus.i_MEM_memWe = we;
      bus.i_MEM_size = sz;
      bus.i_MEM_unsigned = uns;
      bus.i_MEM_regWe = regwe;
      bus.i_MEM_WRA = wra;
      bus.i_MEM_aluOut = alu;
      bus.i_MEM_rd2 = rd2;
      bus.i_MEM_valid = 1'b1;
      c0 = acc_cnt;
      n = 0;
      while (acc_cnt == c0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk("send_accept", 32'(acc_cnt != c0), 1);
      #1 bus.i_MEM_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk("drain", 32'(q.size() == 0), 1);
      #1;
   endtask

   task automatic st(input logic [1:0] sz, input logic [31:0] a, d);
      send(0, 1, sz, 0, 1, 5'd1, a, d);
      drain();
   endtask

   task automatic ld(input logic [1:0] sz, input logic uns,
                     input logic [31:0] a);
      send(1, 0, sz, uns, 1, 5'd7, a, 32'h0);
      drain();
   endtask

   initial begin
      bus.i_MEM_valid = 0; bus.i_MEM_regWe = 0; bus.i_MEM_memRe = 0;
      bus.i_MEM_memWe = 0; bus.i_MEM_size = 0; bus.i_MEM_unsigned = 0;
      bus.i_MEM_WRA = 0; bus.i_MEM_aluOut = 0; bus.i_MEM_rd2 = 0;
      #1 rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;

      // Store, then load back, with wait states.
      rdy_low = 0;
      st(2'd2, 32'h10, 32'hDEADBEEF);
      chk("t2_sw_rdy_low", rdy_low, W);
      rdy_low = 0;
      ld(2'd2, 0, 32'h10);
      chk("t2_lw_rdy_low", rdy_low, W);
      chk("t2_lw_rdata", vlog[$].rdata, 32'hDEADBEEF);
      chk("t2_lw_regwe", 32'(vlog[$].regwe), 1);
      chk("t2_rdata_hold", bus.o_MEM_rData, 32'hDEADBEEF);

      // Byte store into the top lane.
      st(2'd2, 32'h10, 32'h11223344);
      st(2'd0, 32'h13, 32'h123456AA);
      ld(2'd2, 0, 32'h10);
      chk("t3_lw", vlog[$].rdata, 32'hAA223344);
      ld(2'd0, 0, 32'h13);
      chk("t3_lb", vlog[$].rdata, 32'hFFFFFFAA);
      ld(2'd0, 1, 32'h13);
      chk("t3_lbu", vlog[$].rdata, 32'h000000AA);

      // Halfword loads and store.
      ld(2'd1, 0, 32'h12);
      chk("t4_lh", vlog[$].rdata, 32'hFFFFAA22);
      ld(2'd1, 1, 32'h12);
      chk("t4_lhu", vlog[$].rdata, 32'h0000AA22);
      st(2'd1, 32'h10, 32'h99995566);
      ld(2'd2, 0, 32'h10);
      chk("t4_lw", vlog[$].rdata, 32'hAA225566);

      // Misaligned accesses.
      ld(2'd2, 0, 32'h12);
      chk("t5_lw_mis", 32'(vlog[$].mis), 1);
      chk("t5_lw_regwe", 32'(vlog[$].regwe), 0);
      chk("t5_lw_rdata", vlog[$].rdata, 0);
      st(2'd1, 32'h11, 32'h0000FFFF);
      chk("t5_sh_mis", 32'(vlog[$].mis), 1);
      chk("t5_sh_regwe", 32'(vlog[$].regwe), 0);
      st(2'd3, 32'h10, 32'hFFFFFFFF);
      chk("t5_sz3_mis", 32'(vlog[$].mis), 1);
      ld(2'd2, 0, 32'h10);
      chk("t5_unchanged", vlog[$].rdata, 32'hAA225566);

      // Back-to-back ALU ops never wait.
      send(0, 0, 2'd0, 0, 1, 5'd4, 32'd1, 32'd0);
      send(0, 0, 2'd0, 0, 1, 5'd5, 32'd2, 32'd0);
      send(0, 0, 2'd0, 0, 1, 5'd6, 32'd3, 32'd0);
      drain();
      for (int i = 0; i < 3; i++) begin
         chk("t6_alu", vlog[vlog.size()-3+i].alu, 32'(i + 1));
         chk("t6_wra", 32'(vlog[vlog.size()-3+i].wra), 32'(i + 4));
         chk("t6_regwe", 32'(vlog[vlog.size()-3+i].regwe), 1);
         chk("t6_isload", 32'(vlog[vlog.size()-3+i].isload), 0);
      end
      chk("t6_consec", vlog[$].cyc - vlog[vlog.size()-3].cyc, 2);

      // Reset while a store waits: the store is dropped.
      st(2'd2, 32'h20, 32'h0BADC0DE);
      send(0, 1, 2'd2, 0, 0, 5'd0, 32'h20, 32'hCAFEF00D);
      #2 rstn = 1'b0;
      @(negedge clk);
      chk("t1_rst_ready", 32'(bus.o_MEM_ready), 1);
      @(posedge clk);
      #1 rstn = 1'b1;
      ld(2'd2, 0, 32'h20);
      chk("t1_mem_kept", vlog[$].rdata, 32'h0BADC0DE);

      // Random traffic over an initialised window, high bits wrap.
      for (int i = 0; i < 16; i++) st(2'd2, 32'(i * 4), $urandom);
      for (int i = 0; i < 300; i++) begin
         int k;
         logic [31:0] a;
         k = $urandom_range(0, 3);
         a = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
         if (k == 0) a = $urandom;
         send(k == 1 || k == 3, k >= 2, 2'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), 5'($urandom), a, $urandom);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      drain();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

endmodule
